// File: rtl/basic_pkg.sv
// Shared constants and types for basic datapath blocks (direction encoding, counter limit mode).
package basic_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic {
    WRAP     = 1'b0,
    SATURATE = 1'b1
  } counter_mode_e;

endpackage

// File: rtl/updown_mod_counter.sv
// Modulo-N up/down counter with terminal-count decode, sync clear/load, optional saturation
// and registered one-cycle event pulses (wrap, sat, load_err).
module updown_mod_counter #(
  parameter int     WIDTH    = 4,
  parameter longint MODULUS  = 16,
  parameter longint TC_VALUE = MODULUS - 1,
  parameter bit     SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             sat,
  output logic             load_err
);

  localparam basic_pkg::counter_mode_e MODE =
    SATURATE ? basic_pkg::SATURATE : basic_pkg::WRAP;
  localparam logic [WIDTH:0]   MAX_V = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] TC_V  = WIDTH'(TC_VALUE);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("updown_mod_counter: WIDTH must be in 1..32");
  end
  if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
    $error("updown_mod_counter: MODULUS must be in 2..2**WIDTH");
  end
  if (TC_VALUE < 0 || TC_VALUE >= MODULUS) begin : g_bad_tc
    $error("updown_mod_counter: TC_VALUE must be below MODULUS");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             sat_q, sat_d;
  logic             load_err_q, load_err_d;

  logic [WIDTH:0] cnt_ext, up_ext, dn_ext;
  logic           at_top, at_bot, load_ok;

  // One spare bit so the all-ones up step is seen as past the limit instead of overflowing.
  assign cnt_ext = {1'b0, count_q};
  assign up_ext  = cnt_ext + (WIDTH+1)'(1);
  assign dn_ext  = cnt_ext - (WIDTH+1)'(1);
  assign at_top  = up_ext > MAX_V;
  assign at_bot  = dn_ext[WIDTH];
  assign load_ok = {1'b0, load_val} <= MAX_V;

  always_comb begin
    count_d    = count_q;
    wrap_d     = 1'b0;
    sat_d      = 1'b0;
    load_err_d = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      if (load_ok) count_d    = load_val;
      else         load_err_d = 1'b1;
    end else if (en) begin
      if (dir == basic_pkg::DIR_UP) begin
        if (!at_top) begin
          count_d = up_ext[WIDTH-1:0];
        end else if (MODE == basic_pkg::SATURATE) begin
          sat_d = 1'b1;
        end else begin
          count_d = '0;
          wrap_d  = 1'b1;
        end
      end else begin
        if (!at_bot) begin
          count_d = dn_ext[WIDTH-1:0];
        end else if (MODE == basic_pkg::SATURATE) begin
          sat_d = 1'b1;
        end else begin
          count_d = MAX_V[WIDTH-1:0];
          wrap_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      sat_q      <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      sat_q      <= sat_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = count_q;
  assign tc       = (count_q == TC_V);
  assign wrap     = wrap_q;
  assign sat      = sat_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: three configurations share one stimulus bus; each vector
// targets one instance and its expected outputs go through a scoreboard queue.
module tb_updown_mod_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en, dir, clr, load;
  logic [3:0] lv;

  logic [1:0] c0;
  logic [3:0] c1, c2;
  logic       tc0, wr0, sa0, le0;
  logic       tc1, wr1, sa1, le1;
  logic       tc2, wr2, sa2, le2;

  // sel 0: legacy 2-bit (MODULUS == 2**WIDTH), sel 1: mod-10 wrap, sel 2: mod-10 saturate
  updown_mod_counter #(.WIDTH(2), .MODULUS(4), .TC_VALUE(3), .SATURATE(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_val(lv[1:0]), .count(c0), .tc(tc0), .wrap(wr0), .sat(sa0), .load_err(le0));
  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_val(lv), .count(c1), .tc(tc1), .wrap(wr1), .sat(sa1), .load_err(le1));
  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_val(lv), .count(c2), .tc(tc2), .wrap(wr2), .sat(sa2), .load_err(le2));

  typedef struct {
    int         sel;
    logic       en, dir, clr, load;
    logic [3:0] lv;
    logic [3:0] cnt;
    logic       tc, wrap, sat, lerr;
    string      name;
  } vec_t;

  typedef struct {
    int         sel;
    logic [3:0] cnt;
    logic       tc, wrap, sat, lerr;
    string      name;
  } exp_t;

  vec_t tv[$];
  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic vec_t v(int sel, logic e, logic d, logic c, logic l, logic [3:0] val,
                             logic [3:0] cnt, logic t, logic w, logic s, logic le, string nm);
    vec_t r;
    r.sel = sel; r.en = e; r.dir = d; r.clr = c; r.load = l; r.lv = val;
    r.cnt = cnt; r.tc = t; r.wrap = w; r.sat = s; r.lerr = le; r.name = nm;
    return r;
  endfunction

  task automatic expect_out(int sel, logic [3:0] cnt, logic t, logic w, logic s, logic le,
                            string nm);
    exp_t e;
    e.sel = sel; e.cnt = cnt; e.tc = t; e.wrap = w; e.sat = s; e.lerr = le; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic check_one();
    exp_t       e;
    logic [7:0] act, req;
    if (sb.size() == 0) begin
      n_chk++;
      $display("FAIL scoreboard_empty: no expected entry queued");
      return;
    end
    e = sb.pop_front();
    case (e.sel)
      0:       act = {2'b00, c0, tc0, wr0, sa0, le0};
      1:       act = {c1, tc1, wr1, sa1, le1};
      default: act = {c2, tc2, wr2, sa2, le2};
    endcase
    req = {e.cnt, e.tc, e.wrap, e.sat, e.lerr};
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s (dut%0d): got count=%0d tc/wrap/sat/lerr=%b, required count=%0d tc/wrap/sat/lerr=%b",
                  e.name, e.sel, act[7:4], act[3:0], req[7:4], req[3:0]);
  endtask

  task automatic run_vec(vec_t t);
    @(negedge clk);
    en = t.en; dir = t.dir; clr = t.clr; load = t.load; lv = t.lv;
    expect_out(t.sel, t.cnt, t.tc, t.wrap, t.sat, t.lerr, t.name);
    @(posedge clk);
    #1;
    check_one();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; dir = 1'b0; clr = 1'b0; load = 1'b0; lv = 4'd0;

    //            sel en dir clr ld lv     cnt   tc w  s  le
    tv.push_back(v(0, 1, 0, 0, 0, 4'd0, 4'd1, 0, 0, 0, 0, "up2_1"));
    tv.push_back(v(0, 1, 0, 0, 0, 4'd0, 4'd2, 0, 0, 0, 0, "up2_2"));
    tv.push_back(v(0, 1, 0, 0, 0, 4'd0, 4'd3, 1, 0, 0, 0, "up2_3_tc"));
    tv.push_back(v(0, 1, 0, 0, 0, 4'd0, 4'd0, 0, 1, 0, 0, "up2_wrap"));
    tv.push_back(v(0, 1, 0, 0, 0, 4'd0, 4'd1, 0, 0, 0, 0, "up2_wrap_drop"));
    tv.push_back(v(0, 0, 0, 1, 0, 4'd0, 4'd0, 0, 0, 0, 0, "clr2"));
    tv.push_back(v(0, 1, 1, 0, 0, 4'd0, 4'd3, 1, 1, 0, 0, "dn2_wrap"));
    tv.push_back(v(0, 1, 1, 0, 0, 4'd0, 4'd2, 0, 0, 0, 0, "dn2_2"));
    tv.push_back(v(0, 1, 1, 0, 0, 4'd0, 4'd1, 0, 0, 0, 0, "dn2_1"));
    tv.push_back(v(0, 1, 1, 0, 0, 4'd0, 4'd0, 0, 0, 0, 0, "dn2_0"));
    tv.push_back(v(0, 1, 1, 0, 0, 4'd0, 4'd3, 1, 1, 0, 0, "dn2_wrap2"));
    tv.push_back(v(0, 1, 0, 0, 0, 4'd0, 4'd0, 0, 1, 0, 0, "dirflip_up"));
    tv.push_back(v(0, 1, 1, 0, 0, 4'd0, 4'd3, 1, 1, 0, 0, "dirflip_dn"));
    tv.push_back(v(0, 1, 1, 0, 0, 4'd0, 4'd2, 0, 0, 0, 0, "dirflip_dn2"));
    tv.push_back(v(1, 0, 0, 1, 0, 4'd0, 4'd0, 0, 0, 0, 0, "clr10"));
    tv.push_back(v(1, 1, 0, 0, 1, 4'd7, 4'd7, 0, 0, 0, 0, "load7_en_ignored"));
    tv.push_back(v(1, 1, 0, 0, 0, 4'd0, 4'd8, 0, 0, 0, 0, "up10_8"));
    tv.push_back(v(1, 1, 0, 0, 0, 4'd0, 4'd9, 1, 0, 0, 0, "up10_9_tc"));
    tv.push_back(v(1, 1, 0, 0, 0, 4'd0, 4'd0, 0, 1, 0, 0, "up10_wrap"));
    tv.push_back(v(1, 1, 0, 0, 1, 4'd12, 4'd0, 0, 0, 0, 1, "load12_rej"));
    tv.push_back(v(1, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 0, 0, "lerr_drop"));
    tv.push_back(v(1, 0, 0, 0, 1, 4'd9, 4'd9, 1, 0, 0, 0, "load9_edge"));
    tv.push_back(v(1, 0, 0, 0, 1, 4'd10, 4'd9, 1, 0, 0, 1, "load10_rej"));
    tv.push_back(v(1, 1, 1, 0, 0, 4'd0, 4'd8, 0, 0, 0, 0, "dn10_8"));
    tv.push_back(v(2, 0, 0, 1, 0, 4'd0, 4'd0, 0, 0, 0, 0, "clr_sat"));
    tv.push_back(v(2, 0, 0, 0, 1, 4'd8, 4'd8, 0, 0, 0, 0, "load8_sat"));
    tv.push_back(v(2, 1, 0, 0, 0, 4'd0, 4'd9, 1, 0, 0, 0, "sat_up9"));
    tv.push_back(v(2, 1, 0, 0, 0, 4'd0, 4'd9, 1, 0, 1, 0, "sat_hold1"));
    tv.push_back(v(2, 1, 0, 0, 0, 4'd0, 4'd9, 1, 0, 1, 0, "sat_hold2"));
    tv.push_back(v(2, 0, 0, 0, 0, 4'd0, 4'd9, 1, 0, 0, 0, "sat_drop"));
    tv.push_back(v(2, 0, 0, 1, 0, 4'd0, 4'd0, 0, 0, 0, 0, "clr_sat2"));
    tv.push_back(v(2, 1, 1, 0, 0, 4'd0, 4'd0, 0, 0, 1, 0, "sat_dn0"));
    tv.push_back(v(2, 0, 1, 0, 0, 4'd0, 4'd0, 0, 0, 0, 0, "sat_dn_drop"));
    tv.push_back(v(1, 1, 0, 1, 1, 4'd5, 4'd0, 0, 0, 0, 0, "prio_clr"));
    tv.push_back(v(1, 1, 0, 0, 1, 4'd5, 4'd5, 0, 0, 0, 0, "prio_load"));
    tv.push_back(v(1, 1, 0, 0, 0, 4'd0, 4'd6, 0, 0, 0, 0, "prio_up6"));
    tv.push_back(v(1, 0, 0, 0, 1, 4'd12, 4'd6, 0, 0, 0, 1, "pre_rst_lerr"));

    // Reset values observed while rst_n is still low
    #12;
    expect_out(0, 4'd0, 0, 0, 0, 0, "rst_dut0"); check_one();
    expect_out(1, 4'd0, 0, 0, 0, 0, "rst_dut1"); check_one();
    expect_out(2, 4'd0, 0, 0, 0, 0, "rst_dut2"); check_one();
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tv[i]) run_vec(tv[i]);

    // Async reset between edges while count=6 and load_err is high
    #2;
    rst_n = 1'b0;
    #1;
    expect_out(1, 4'd0, 0, 0, 0, 0, "async_rst_dut1"); check_one();
    expect_out(0, 4'd0, 0, 0, 0, 0, "async_rst_dut0"); check_one();
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1; dir = 1'b0; clr = 1'b0; load = 1'b0; lv = 4'd0;
    expect_out(1, 4'd1, 0, 0, 0, 0, "resume_after_rst");
    @(posedge clk);
    #1;
    check_one();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/updown_mod_counter.md
Name: updown_mod_counter

Overview:
Parametrised modulo-N up/down counter with terminal-count decode. It generalises the team's 2-bit direction-controlled sequence counter, whose Y output asserts at state 3, to arbitrary width and modulus. It adds enable, synchronous clear and load, optional saturation, and registered event pulses. It is used as a reusable sequencer and timebase in basic datapath blocks.

Parameters:
WIDTH, 4, counter width in bits; legal range 1..32.
MODULUS, 16, count range is 0..MODULUS-1; legal range 2..2**WIDTH; elaboration error otherwise.
TC_VALUE, MODULUS-1, count value that asserts tc; must be < MODULUS.
SATURATE, 0, 0 = wrap at limits, 1 = hold at limits.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
en  in  1  count enable
dir  in  1  0 = count up, 1 = count down
clr  in  1  synchronous clear to 0
load  in  1  synchronous load of load_val
load_val  in  WIDTH  value to load
count  out  WIDTH  current count, registered
tc  out  1  count == TC_VALUE; decoded from the count register only, with no input in the path
wrap  out  1  registered pulse: the count wrapped on the last edge
sat  out  1  registered pulse: an enabled step was blocked at a limit (SATURATE=1 only)
load_err  out  1  registered pulse: the last load was rejected

Behaviour:
- Reset (rst_n=0, asynchronous):
  - count=0; wrap=0; sat=0; load_err=0.
  - tc=1 if TC_VALUE==0, else tc=0.
  - Release is synchronous to clk: the first update happens at the first rising edge with rst_n=1.
- Priority per rising edge: clr > load > en > hold.
- clr=1: count<=0. load and en are ignored. All pulses go to 0.
- load=1, clr=0:
  - If load_val < MODULUS: count<=load_val, load_err<=0.
  - Otherwise: count holds and load_err<=1 for one cycle.
  - en is ignored in the load cycle.
- en=1, dir=0 (up):
  - count < MODULUS-1: count<=count+1.
  - count==MODULUS-1 and SATURATE=0: count<=0, wrap<=1.
  - count==MODULUS-1 and SATURATE=1: count holds, sat<=1.
- en=1, dir=1 (down):
  - count > 0: count<=count-1.
  - count==0 and SATURATE=0: count<=MODULUS-1, wrap<=1.
  - count==0 and SATURATE=1: count holds, sat<=1.
- en=0: count holds.
- wrap, sat and load_err are high for exactly one cycle after their causing edge, and 0 on every other edge.
- dir may change on any cycle. The new direction takes effect on the same edge, with no dead cycle.
- Arithmetic: compute the next value in WIDTH+1 bits, then compare against MODULUS-1. When MODULUS == 2**WIDTH, no out-of-range value may ever appear on count, including on the up-wrap from the all-ones value.
- Legacy equivalence: with WIDTH=2, MODULUS=4, TC_VALUE=3, SATURATE=0, en=1, clr=0, load=0, the block matches the 2-bit sequence counter cycle for cycle (dir equals that counter's A input, tc equals Y).
- Reset asserted mid-count: all outputs return to their reset values immediately, without waiting for a clock edge.

Decomposition:
- Shared package basic_pkg:
  - DIR_UP=1'b0 and DIR_DOWN=1'b1 constants.
  - A counter_mode_e enum (WRAP, SATURATE), used for the SATURATE parameter.
- Single module. The next-state logic stays inline; no sub-module is warranted.

Test Plan:
- WIDTH=2, MODULUS=4, en=1, dir=0 for 5 cycles from reset -> count 0,1,2,3,0; tc high only at 3; wrap high in the cycle after the 3->0 edge.
- Same configuration with dir=1 -> count 0,3,2,1,0; wrap pulses after the 0->3 edge; tc high at 3.
- WIDTH=4, MODULUS=10:
  - load 7, then count up 3 cycles -> 8,9,0 with one wrap pulse.
  - load 12 -> count stays unchanged, load_err pulses 1 cycle.
- SATURATE=1, MODULUS=10:
  - count up from 8 for 3 cycles -> 9,9,9; sat pulses twice; wrap stays 0.
  - count down from 0 -> stays 0; sat=1.
- Priority: clr=1, load=1 (val 5) and en=1 on the same edge -> count=0.
  - Next cycle, load=1, en=1 -> count=5, with no increment in the load cycle.
- Reset mid-count: assert rst_n=0 between edges at count=6 -> count=0 and pulses=0 immediately. Release -> counting resumes from 0 at the first edge.
